trace_commit_buffer: RTL and testbench

Multi-channel commit-trace capture buffer sitting beside the CPU core in the top-level shell. Each cycle it accepts up to COMMIT_WIDTH retiring instructions (pc, destination register, write data) plus one data-SRAM write record. It compacts them in program order into a circular FIFO and drains them one entry per cycle over a valid/ready stream to the difftest/trace consumer. When the FIFO lacks room it drops whole cycles and reports the loss, rather than back-pressuring the core.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_compact.sv | 30 +++
 rtl/trace_commit_buffer.sv | 163 ++++++++++++++++
 tb/tb_trace_commit_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and widths for the commit-trace capture buffer.
package trace_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WNUM_W     = 5;
    localparam int unsigned WEN_W      = XLEN / 8;
    localparam int unsigned DROP_CNT_W = 16;

    // One FIFO slot: an instruction commit or a standalone SRAM-write record.
    typedef struct packed {
        logic              commit;
        logic              gap;
        logic [XLEN-1:0]   pc;
        logic [WNUM_W-1:0] rf_wnum;
        logic [XLEN-1:0]   rf_wdata;
        logic [WEN_W-1:0]  sram_wen;
        logic [ADDR_W-1:0] sram_waddr;
        logic [XLEN-1:0]   sram_wdata;
    } trace_entry_t;

endpackage

// File: rtl/trace_compact.sv
// Combinational compaction helper: per-channel slot offsets (prefix popcount),
// total valid count and index of the youngest valid channel.
module trace_compact #(
    parameter int unsigned  COMMIT_WIDTH = 2,
    localparam int unsigned N_W          = $clog2(COMMIT_WIDTH + 1),
    localparam int unsigned IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  logic [COMMIT_WIDTH-1:0]          commit,
    output logic [COMMIT_WIDTH-1:0][N_W-1:0] offset,
    output logic [N_W-1:0]                   n,
    output logic [IDX_W-1:0]                 youngest
);

    // Walk channels oldest-first, accumulating the slot index of each valid one.
    always_comb begin
        logic [N_W-1:0] acc;
        acc      = '0;
        offset   = '0;
        youngest = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            offset[i] = acc;
            if (commit[i]) begin
                acc      = acc + N_W'(1);
                youngest = IDX_W'(i);
            end
        end
        n = acc;
    end

endmodule

// File: rtl/trace_commit_buffer.sv
// Commit-trace capture FIFO: compacts up to COMMIT_WIDTH retiring instructions
// per cycle, drops whole cycles when short of room, drains one entry per cycle.
module trace_commit_buffer
    import trace_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [COMMIT_WIDTH-1:0]          in_commit,
    input  logic [COMMIT_WIDTH*XLEN-1:0]     in_pc,
    input  logic [COMMIT_WIDTH*WNUM_W-1:0]   in_rf_wnum,
    input  logic [COMMIT_WIDTH*XLEN-1:0]     in_rf_wdata,
    input  logic [WEN_W-1:0]                 in_sram_wen,
    input  logic [ADDR_W-1:0]                in_sram_waddr,
    input  logic [XLEN-1:0]                  in_sram_wdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_commit,
    output logic [XLEN-1:0]                  out_pc,
    output logic [WNUM_W-1:0]                out_rf_wnum,
    output logic [XLEN-1:0]                  out_rf_wdata,
    output logic [WEN_W-1:0]                 out_sram_wen,
    output logic [ADDR_W-1:0]                out_sram_waddr,
    output logic [XLEN-1:0]                  out_sram_wdata,
    output logic                             out_gap,
    output logic                             almost_full,
    output logic                             overflow,
    output logic [DROP_CNT_W-1:0]            drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned N_W   = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

    trace_entry_t storage [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             gap_pending;

    logic [COMMIT_WIDTH-1:0][N_W-1:0] offset;
    logic [N_W-1:0]                   n_commit;
    logic [IDX_W-1:0]                 youngest;

    logic             sram_only;
    logic [N_W-1:0]   demand;
    logic [CNT_W-1:0] free_slots;
    logic             drop;
    logic             admit;
    logic             deq;
    logic [CNT_W-1:0] admit_n;
    logic [CNT_W-1:0] count_next;

    logic [COMMIT_WIDTH-1:0] wr_en;
    logic [PTR_W-1:0]        wr_slot  [COMMIT_WIDTH];
    trace_entry_t            wr_entry [COMMIT_WIDTH];
    trace_entry_t            head;

    trace_compact #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_compact (
        .commit   (in_commit),
        .offset   (offset),
        .n        (n_commit),
        .youngest (youngest)
    );

    // All-or-nothing admission against the room available at the start of the cycle.
    always_comb begin
        sram_only  = (in_commit == '0) && (in_sram_wen != '0);
        demand     = sram_only ? N_W'(1) : n_commit;
        free_slots = CNT_W'(DEPTH) - count;
        drop       = (demand != '0) && (CNT_W'(demand) > free_slots);
        admit      = (demand != '0) && !drop;
        deq        = out_valid && out_ready;
        admit_n    = admit ? CNT_W'(demand) : CNT_W'(0);
        count_next = count + admit_n - CNT_W'(deq);
    end

    // Build per-channel write entries; the SRAM record rides on the youngest commit.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wr_en[i]               = admit && in_commit[i];
            wr_slot[i]             = wr_ptr + PTR_W'(offset[i]);
            wr_entry[i].commit     = 1'b1;
            wr_entry[i].gap        = gap_pending && (offset[i] == '0);
            wr_entry[i].pc         = in_pc[i*XLEN +: XLEN];
            wr_entry[i].rf_wnum    = in_rf_wnum[i*WNUM_W +: WNUM_W];
            wr_entry[i].rf_wdata   = in_rf_wdata[i*XLEN +: XLEN];
            wr_entry[i].sram_wen   = '0;
            wr_entry[i].sram_waddr = '0;
            wr_entry[i].sram_wdata = '0;
            if (IDX_W'(i) == youngest) begin
                wr_entry[i].sram_wen   = in_sram_wen;
                wr_entry[i].sram_waddr = in_sram_waddr;
                wr_entry[i].sram_wdata = in_sram_wdata;
            end
        end
        if (sram_only && admit) begin
            wr_en[0]               = 1'b1;
            wr_slot[0]             = wr_ptr;
            wr_entry[0]            = '0;
            wr_entry[0].gap        = gap_pending;
            wr_entry[0].sram_wen   = in_sram_wen;
            wr_entry[0].sram_waddr = in_sram_waddr;
            wr_entry[0].sram_wdata = in_sram_wdata;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (wr_en[i]) begin
                storage[wr_slot[i]] <= wr_entry[i];
            end
        end
    end

    // Pointers, occupancy and loss bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            gap_pending <= 1'b0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PTR_W'(admit_n);
            rd_ptr      <= rd_ptr + PTR_W'(deq);
            count       <= count_next;
            almost_full <= (CNT_W'(DEPTH) - count_next) < CNT_W'(2 * COMMIT_WIDTH);
            if (drop) begin
                overflow    <= 1'b1;
                gap_pending <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_CNT_W'(1);
                end
            end else if (admit) begin
                gap_pending <= 1'b0;
            end
        end
    end

    // Head entry drives the stream directly; zeroed while the FIFO is empty.
    always_comb begin
        out_valid      = (count != '0);
        head           = out_valid ? storage[rd_ptr] : '0;
        out_commit     = head.commit;
        out_gap        = head.gap;
        out_pc         = head.pc;
        out_rf_wnum    = head.rf_wnum;
        out_rf_wdata   = head.rf_wdata;
        out_sram_wen   = head.sram_wen;
        out_sram_waddr = head.sram_waddr;
        out_sram_wdata = head.sram_wdata;
    end

endmodule

// File: tb/tb_trace_commit_buffer.sv
// Directed bench for trace_commit_buffer with hand-computed expectations.
module tb_trace_commit_buffer;
    import trace_pkg::*;

    localparam int unsigned CW = 2;

    logic                    clock;
    logic                    reset;
    logic [CW-1:0]           in_commit;
    logic [CW*XLEN-1:0]      in_pc;
    logic [CW*WNUM_W-1:0]    in_rf_wnum;
    logic [CW*XLEN-1:0]      in_rf_wdata;
    logic [WEN_W-1:0]        in_sram_wen;
    logic [ADDR_W-1:0]       in_sram_waddr;
    logic [XLEN-1:0]         in_sram_wdata;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_commit;
    logic [XLEN-1:0]         out_pc;
    logic [WNUM_W-1:0]       out_rf_wnum;
    logic [XLEN-1:0]         out_rf_wdata;
    logic [WEN_W-1:0]        out_sram_wen;
    logic [ADDR_W-1:0]       out_sram_waddr;
    logic [XLEN-1:0]         out_sram_wdata;
    logic                    out_gap;
    logic                    almost_full;
    logic                    overflow;
    logic [DROP_CNT_W-1:0]   drop_count;

    int tests  = 0;
    int failed = 0;

    trace_commit_buffer #(.COMMIT_WIDTH(CW), .DEPTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_commit      (in_commit),
        .in_pc          (in_pc),
        .in_rf_wnum     (in_rf_wnum),
        .in_rf_wdata    (in_rf_wdata),
        .in_sram_wen    (in_sram_wen),
        .in_sram_waddr  (in_sram_waddr),
        .in_sram_wdata  (in_sram_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_commit     (out_commit),
        .out_pc         (out_pc),
        .out_rf_wnum    (out_rf_wnum),
        .out_rf_wdata   (out_rf_wdata),
        .out_sram_wen   (out_sram_wen),
        .out_sram_waddr (out_sram_waddr),
        .out_sram_wdata (out_sram_wdata),
        .out_gap        (out_gap),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_commit     = '0;
        in_sram_wen   = '0;
        in_sram_waddr = '0;
        in_sram_wdata = '0;
    endtask

    task automatic set_ch(input int ch, input logic [63:0] pc, input logic [4:0] wn, input logic [63:0] wd);
        in_commit[ch]             = 1'b1;
        in_pc[ch*XLEN +: XLEN]    = pc;
        in_rf_wnum[ch*5 +: 5]     = wn;
        in_rf_wdata[ch*XLEN +: XLEN] = wd;
    endtask

    initial begin
        reset       = 1'b0;
        out_ready   = 1'b0;
        in_pc       = '0;
        in_rf_wnum  = '0;
        in_rf_wdata = '0;
        idle();

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);
        check("rst_gap", 64'(out_gap), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single commit on ch0
        out_ready = 1'b1;
        set_ch(0, 64'h8000_0000, 5'd5, 64'h1234);
        cycle();
        idle();
        check("s_valid", 64'(out_valid), 64'd1);
        check("s_commit", 64'(out_commit), 64'd1);
        check("s_gap", 64'(out_gap), 64'd0);
        check("s_pc", out_pc, 64'h8000_0000);
        check("s_wnum", 64'(out_rf_wnum), 64'd5);
        check("s_wdata", out_rf_wdata, 64'h1234);
        check("s_wen", 64'(out_sram_wen), 64'd0);
        cycle();
        check("s_empty", 64'(out_valid), 64'd0);

        // Dual commit with SRAM record on the youngest
        set_ch(0, 64'h100, 5'd1, 64'h11);
        set_ch(1, 64'h104, 5'd2, 64'h22);
        in_sram_wen   = 8'hFF;
        in_sram_waddr = 32'h2000;
        in_sram_wdata = 64'hDEAD;
        cycle();
        idle();
        check("d0_pc", out_pc, 64'h100);
        check("d0_wen", 64'(out_sram_wen), 64'd0);
        cycle();
        check("d1_pc", out_pc, 64'h104);
        check("d1_wnum", 64'(out_rf_wnum), 64'd2);
        check("d1_wen", 64'(out_sram_wen), 64'hFF);
        check("d1_waddr", 64'(out_sram_waddr), 64'h2000);
        check("d1_wdata", out_sram_wdata, 64'hDEAD);
        cycle();
        check("d_empty", 64'(out_valid), 64'd0);

        // Standalone SRAM record
        in_sram_wen   = 8'h0F;
        in_sram_waddr = 32'h3000;
        in_sram_wdata = 64'h55;
        cycle();
        idle();
        check("m_valid", 64'(out_valid), 64'd1);
        check("m_commit", 64'(out_commit), 64'd0);
        check("m_wen", 64'(out_sram_wen), 64'h0F);
        check("m_waddr", 64'(out_sram_waddr), 64'h3000);
        cycle();
        check("m_empty", 64'(out_valid), 64'd0);

        // Fill with ready low: 8 cycles admitted, 9th dropped
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            idle();
            set_ch(0, 64'h1000 + 64'(8 * k), 5'd1, 64'(k));
            set_ch(1, 64'h1004 + 64'(8 * k), 5'd2, 64'(k));
            cycle();
            if (k == 5) check("f_af_at12", 64'(almost_full), 64'd0);
            if (k == 7) check("f_ovf_at16", 64'(overflow), 64'd0);
        end
        check("f_ovf", 64'(overflow), 64'd1);
        check("f_drops1", 64'(drop_count), 64'd1);
        check("f_af", 64'(almost_full), 64'd1);
        check("f_head", out_pc, 64'h1000);

        // Two more drops
        for (int k = 0; k < 2; k++) begin
            idle();
            set_ch(0, 64'h9000, 5'd3, 64'h0);
            set_ch(1, 64'h9004, 5'd4, 64'h0);
            cycle();
        end
        check("f_drops3", 64'(drop_count), 64'd3);
        check("f_hold", out_pc, 64'h1000);

        // Drain two, then admit a pair carrying the gap marker
        idle();
        out_ready = 1'b1;
        check("g_pc0", out_pc, 64'h1000);
        cycle();
        check("g_pc1", out_pc, 64'h1004);
        cycle();
        check("g_pc2", out_pc, 64'h1008);
        set_ch(0, 64'h2000, 5'd6, 64'h60);
        set_ch(1, 64'h2004, 5'd7, 64'h70);
        cycle();
        idle();
        check("g_drops", 64'(drop_count), 64'd3);
        for (int k = 0; k < 13; k++) begin
            check("g_drain_pc", out_pc, 64'h100C + 64'(4 * k));
            check("g_drain_gap", 64'(out_gap), 64'd0);
            cycle();
        end
        check("g_new0_pc", out_pc, 64'h2000);
        check("g_new0_gap", 64'(out_gap), 64'd1);
        cycle();
        check("g_new1_pc", out_pc, 64'h2004);
        check("g_new1_gap", 64'(out_gap), 64'd0);
        cycle();
        check("g_empty", 64'(out_valid), 64'd0);
        check("g_ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset with 5 entries pending
        out_ready = 1'b0;
        set_ch(0, 64'h3000, 5'd1, 64'h1);
        set_ch(1, 64'h3004, 5'd1, 64'h2);
        cycle();
        cycle();
        idle();
        set_ch(0, 64'h3010, 5'd1, 64'h3);
        cycle();
        idle();
        check("r_pending", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("r_valid", 64'(out_valid), 64'd0);
        check("r_ovf", 64'(overflow), 64'd0);
        check("r_drops", 64'(drop_count), 64'd0);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        set_ch(0, 64'h4000, 5'd7, 64'h77);
        cycle();
        idle();
        check("r_post_valid", 64'(out_valid), 64'd1);
        check("r_post_pc", out_pc, 64'h4000);
        check("r_post_gap", 64'(out_gap), 64'd0);
        cycle();
        check("r_post_empty", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
